// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator with frame-latched sync offsets and pipeline alignment
module video_timing_gen #(
    parameter int H_TOTAL  = 456,
    parameter int H_ACTIVE = 336,
    parameter int H_SYNC_S = 360,
    parameter int H_SYNC_W = 24,
    parameter int V_TOTAL  = 262,
    parameter int V_ACTIVE = 240,
    parameter int V_SYNC_S = 240,
    parameter int V_SYNC_W = 3,
    parameter int CNT_W    = 9,
    parameter int OFFS_W   = 5,
    parameter int PIPE     = 1,
    parameter int RGB_W    = 8
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     ce_pix,
    input  logic signed [OFFS_W-1:0] h_offs,
    input  logic signed [OFFS_W-1:0] v_offs,
    input  logic [RGB_W-1:0]         rgb_in,
    output logic [CNT_W-1:0]         hpos,
    output logic [CNT_W-1:0]         vpos,
    output logic [RGB_W-1:0]         rgb_out,
    output logic                     hblank,
    output logic                     vblank,
    output logic                     hs_n,
    output logic                     vs_n,
    output logic                     frame_st
);

    localparam int SW = CNT_W + 2;
    // Flag order {hb, vb, hs, vs}; blank state has both blanks set, syncs idle.
    localparam logic [3:0] BLANK_FLAGS = 4'b1100;

    function automatic logic signed [SW-1:0] clamp(
        input logic signed [SW-1:0] x,
        input logic signed [SW-1:0] lo,
        input logic signed [SW-1:0] hi
    );
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    logic [CNT_W-1:0]         hcnt;
    logic [CNT_W-1:0]         vcnt;
    logic signed [OFFS_W-1:0] h_offs_q;
    logic signed [OFFS_W-1:0] v_offs_q;
    logic                     h_wrap;
    logic                     v_wrap;

    assign h_wrap = (hcnt == CNT_W'(H_TOTAL - 1));
    assign v_wrap = (vcnt == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            hcnt     <= '0;
            vcnt     <= '0;
            h_offs_q <= '0;
            v_offs_q <= '0;
        end else if (ce_pix) begin
            if (h_wrap) begin
                hcnt <= '0;
                if (v_wrap) begin
                    vcnt     <= '0;
                    h_offs_q <= h_offs;
                    v_offs_q <= v_offs;
                end else begin
                    vcnt <= vcnt + 1'b1;
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    // Sync starts are clamped so the pulse never enters the active area or runs past the line/frame end.
    logic signed [SW-1:0] hs_s;
    logic signed [SW-1:0] vs_s;
    logic signed [SW-1:0] hc_s;
    logic signed [SW-1:0] vc_s;
    logic [3:0]           raw_flags;
    logic [3:0]           dly_flags;

    assign hs_s = clamp(SW'(H_SYNC_S) + SW'(h_offs_q), SW'(H_ACTIVE), SW'(H_TOTAL - H_SYNC_W));
    assign vs_s = clamp(SW'(V_SYNC_S) + SW'(v_offs_q), SW'(V_ACTIVE), SW'(V_TOTAL - V_SYNC_W));
    assign hc_s = $signed({2'b00, hcnt});
    assign vc_s = $signed({2'b00, vcnt});

    assign raw_flags = {
        (hcnt >= CNT_W'(H_ACTIVE)),
        (vcnt >= CNT_W'(V_ACTIVE)),
        (hc_s >= hs_s) && (hc_s < hs_s + SW'(H_SYNC_W)),
        (vc_s >= vs_s) && (vc_s < vs_s + SW'(V_SYNC_W))
    };

    generate
        if (PIPE == 0) begin : g_no_dly
            assign dly_flags = raw_flags;
        end else begin : g_dly
            logic [3:0] sr [PIPE];
            always_ff @(posedge clk_sys) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) sr[i] <= BLANK_FLAGS;
                end else if (ce_pix) begin
                    sr[0] <= raw_flags;
                    for (int i = 1; i < PIPE; i++) sr[i] <= sr[i-1];
                end
            end
            assign dly_flags = sr[PIPE-1];
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            rgb_out <= '0;
            hblank  <= 1'b1;
            vblank  <= 1'b1;
            hs_n    <= 1'b1;
            vs_n    <= 1'b1;
        end else if (ce_pix) begin
            rgb_out <= (dly_flags[3] | dly_flags[2]) ? '0 : rgb_in;
            hblank  <= dly_flags[3];
            vblank  <= dly_flags[2];
            hs_n    <= ~dly_flags[1];
            vs_n    <= ~dly_flags[0];
        end
    end

    assign hpos     = hcnt;
    assign vpos     = vcnt;
    assign frame_st = ce_pix && (hcnt == '0) && (vcnt == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized model-checked bench for video_timing_gen
module tb_video_timing_gen;

    localparam int HT = 40, HA = 24, HSS = 28, HSW = 4;
    localparam int VT = 20, VA = 14, VSS = 15, VSW = 2;
    localparam int P = 3;
    localparam int FR = HT * VT;
    localparam int HSZ = 8192;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ce_pix = 1'b0;
    logic signed [4:0] h_offs = '0;
    logic signed [4:0] v_offs = '0;
    logic [7:0]        rgb_in = '0;
    logic [8:0]        hpos, vpos;
    logic [7:0]        rgb_out;
    logic              hblank, vblank, hs_n, vs_n, frame_st;

    video_timing_gen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_S(HSS), .H_SYNC_W(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_S(VSS), .V_SYNC_W(VSW),
        .CNT_W(9), .OFFS_W(5), .PIPE(P), .RGB_W(8)
    ) dut (
        .clk_sys(clk), .rst_n(rst_n), .ce_pix(ce_pix),
        .h_offs(h_offs), .v_offs(v_offs), .rgb_in(rgb_in),
        .hpos(hpos), .vpos(vpos), .rgb_out(rgb_out),
        .hblank(hblank), .vblank(vblank), .hs_n(hs_n), .vs_n(vs_n),
        .frame_st(frame_st)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int rgb_hist [HSZ];
    int hh [HSZ];
    int vh [HSZ];
    bit chk_en = 0;
    int lit_mode = 0;
    bit core_rgb = 0;
    bit rand_ce = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d (tick %0d, t=%0t)", nm, act, exp, n, $time);
        end
    endtask

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    // Expected registered outputs after k ticks since reset: {rgb, hb, vb, hs_n, vs_n}.
    function automatic logic [11:0] model_out(input int k);
        int m, h, v, f, ho, vo, hss, vss;
        bit hb, vb, hs, vs;
        logic [7:0] rgb;
        m = k - P - 1;
        if (m < 0) return {8'h00, 4'b1111};
        h = m % HT;
        v = (m / HT) % VT;
        f = m / FR;
        ho = (f == 0) ? 0 : hh[f*FR-1];
        vo = (f == 0) ? 0 : vh[f*FR-1];
        hss = clampi(HSS + ho, HA, HT - HSW);
        vss = clampi(VSS + vo, VA, VT - VSW);
        hb = (h >= HA);
        vb = (v >= VA);
        hs = (h >= hss) && (h < hss + HSW);
        vs = (v >= vss) && (v < vss + VSW);
        rgb = (hb || vb) ? 8'h00 : 8'(rgb_hist[k-1]);
        return {rgb, hb, vb, !hs, !vs};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) n = 0;
        else if (ce_pix && n < HSZ) begin
            rgb_hist[n] = int'(rgb_in);
            hh[n] = int'(h_offs);
            vh[n] = int'(v_offs);
            n = n + 1;
        end
    end

    int  fs_gap = 0;
    bit  fs_seen = 0;
    logic [11:0] e;

    always @(negedge clk) begin
        if (chk_en) begin
            e = model_out(n);
            chk("hpos", int'(hpos), n % HT);
            chk("vpos", int'(vpos), (n / HT) % VT);
            chk("frame_st", int'(frame_st), int'(ce_pix && (n % FR == 0)));
            chk("rgb_out", int'(rgb_out), int'(e[11:4]));
            chk("hblank", int'(hblank), int'(e[3]));
            chk("vblank", int'(vblank), int'(e[2]));
            chk("hs_n", int'(hs_n), int'(e[1]));
            chk("vs_n", int'(vs_n), int'(e[0]));
            if (!rst_n) begin
                fs_seen = 0;
                fs_gap = 0;
            end else if (ce_pix) begin
                if (frame_st) begin
                    if (fs_seen) chk("frame_period", fs_gap, 800);
                    fs_seen = 1;
                    fs_gap = 0;
                end
                fs_gap++;
            end
            if (vpos >= 3 && vpos <= 12) begin
                if (lit_mode == 1) begin
                    if (hpos == 4)  begin chk("lit_first_px", int'(rgb_out), 0);  chk("lit_hb_4", int'(hblank), 0); end
                    if (hpos == 27) begin chk("lit_last_px", int'(rgb_out), 23); chk("lit_hb_27", int'(hblank), 0); end
                    if (hpos == 28) begin chk("lit_hb_28", int'(hblank), 1); chk("lit_px_28", int'(rgb_out), 0); end
                    if (hpos == 31) chk("lit_hs0_31", int'(hs_n), 1);
                    if (hpos == 32) chk("lit_hs0_32", int'(hs_n), 0);
                end else if (lit_mode == 2) begin
                    if (hpos == 35) chk("lit_hs4_35", int'(hs_n), 1);
                    if (hpos == 36) chk("lit_hs4_36", int'(hs_n), 0);
                    if (hpos == 39) chk("lit_hs4_39", int'(hs_n), 0);
                    if (hpos == 0)  chk("lit_hs4_0", int'(hs_n), 1);
                end else if (lit_mode == 3) begin
                    if (hpos == 39) chk("lit_hs15_39", int'(hs_n), 1);
                    if (hpos == 0)  chk("lit_hs15_0", int'(hs_n), 0);
                    if (hpos == 3)  chk("lit_hs15_3", int'(hs_n), 0);
                    if (hpos == 4)  chk("lit_hs15_4", int'(hs_n), 1);
                end
            end
        end
    end

    int cyc = 0;

    task automatic step();
        if (rand_ce) ce_pix = 1'($urandom_range(0, 1));
        else ce_pix = (cyc % 4 == 3);
        if (core_rgb) rgb_in = (n >= P) ? 8'((n - P) % HT) : 8'h00;
        else rgb_in = 8'($urandom);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int tgt);
        int budget;
        budget = 0;
        while (n < tgt && budget < 20000) begin
            step();
            budget++;
        end
        if (n < tgt) chk("run_timeout", n, tgt);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", int'(rgb_out), 0);
        chk("rst_hblank", int'(hblank), 1);
        chk("rst_vblank", int'(vblank), 1);
        chk("rst_hs_n", int'(hs_n), 1);
        chk("rst_vs_n", int'(vs_n), 1);
        chk("rst_frame_st", int'(frame_st), 0);
        chk_en = 1;
        rst_n = 1'b1;

        core_rgb = 1;
        lit_mode = 1;
        run_until(700);
        lit_mode = 0;
        h_offs = 5'sd4;
        run_until(FR + 120);
        lit_mode = 2;
        run_until(FR + 200);
        h_offs = -5'sd8;
        run_until(FR + 500);
        lit_mode = 0;

        core_rgb = 0;
        rand_ce = 1;
        run_until(2 * FR + 300);
        h_offs = 5'sd15;
        v_offs = -5'sd16;
        run_until(3 * FR + 120);
        lit_mode = 3;
        run_until(3 * FR + 500);
        lit_mode = 0;

        while (n < 6 * FR) begin
            run_until(n + int'($urandom_range(50, 300)));
            h_offs = 5'($urandom);
            v_offs = 5'($urandom);
        end

        rand_ce = 0;
        run_until(6 * FR + 5 * HT + 20);
        while (!(ce_pix == 1'b0 && hpos == 9'd20)) step();
        rst_n = 1'b0;
        ce_pix = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ce_pix = 1'b0;
        chk("mid_rst_hblank", int'(hblank), 1);
        chk("mid_rst_vblank", int'(vblank), 1);
        chk("mid_rst_hs_n", int'(hs_n), 1);
        chk("mid_rst_vs_n", int'(vs_n), 1);
        chk("mid_rst_rgb", int'(rgb_out), 0);
        chk("mid_rst_hpos", int'(hpos), 0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("freeze_hpos", int'(hpos), 0);
        chk("freeze_hblank", int'(hblank), 1);

        rand_ce = 1;
        run_until(FR + 100);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
